// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg -- parametrised, stallable multi-stage pipeline register.
//
// A chain of `depth` register stages, each with its own valid bit, moving
// n-bit items from d to q under a valid/ready handshake. Items slide forward
// into empty stages even while the output is stalled, so holes close up
// toward the output. A synchronous flush discards everything stored. The
// number of valid stages is kept in a registered counter.
//
// Parameters:
//   n            data width in bits (>= 1)
//   depth        number of register stages (>= 1)
//   reset_value  value loaded into every data stage on reset
//
// Ports:
//   clk        in   1                   rising-edge clock
//   reset      in   1                   asynchronous reset, active low
//   flush      in   1                   synchronous flush of all stored items
//   in_valid   in   1                   upstream presents d
//   in_ready   out  1                   pipe accepts d this cycle
//   d          in   n                   data in
//   out_valid  out  1                   q holds a valid item
//   out_ready  in   1                   downstream accepts q this cycle
//   q          out  n                   data out (last stage register)
//   count      out  $clog2(depth+1)     number of valid stages
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int unsigned   n           = 32,
    parameter int unsigned   depth       = 2,
    parameter logic [n-1:0]  reset_value = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [n-1:0]                 d,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [n-1:0]                 q,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(depth + 1);

    logic [n-1:0]     r_data [depth];
    logic [depth-1:0] r_valid;
    logic [CW-1:0]    r_count;

    logic [depth-1:0] w_adv;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // A stage may load when it is empty or its successor is loading this edge.
    // The chain is walked from the output end; a local carry avoids a
    // self-referencing vector.
    always_comb begin : adv_chain
        logic chain;
        chain = out_ready;
        w_adv = '0;
        for (int i = int'(depth) - 1; i >= 0; i--) begin
            chain    = !r_valid[i] || chain;
            w_adv[i] = chain;
        end
    end

    // reset is asynchronous, so gating with it drops in_ready immediately.
    assign in_ready   = w_adv[0] && !flush && reset;
    assign out_valid  = r_valid[depth-1];
    assign q          = r_data[depth-1];
    assign count      = r_count;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(depth); i++) begin
                r_data[i] <= reset_value;
            end
        end else if (flush) begin
            // Data registers hold; only the valid bits and count are cleared.
            r_valid <= '0;
            r_count <= '0;
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= d;
                end
            end
            for (int i = 1; i < int'(depth); i++) begin
                if (w_adv[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    // Moving a bubble forward leaves the old data in place.
                    if (r_valid[i-1]) begin
                        r_data[i] <= r_data[i-1];
                    end
                end
            end
            unique case ({w_in_xfer, w_out_xfer})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg -- directed, self-checking bench for pipe_reg.
//
// Two instances share clock and reset: a depth-3 pipe for reset, streaming,
// back-pressure, bubble collapse and flush, and a depth-1 pipe for
// single-stage throughput and stall behaviour. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_reg;

    logic        clk;
    logic        reset;

    // depth = 3 instance
    logic        flush3;
    logic        in_valid3;
    logic        in_ready3;
    logic [31:0] d3;
    logic        out_valid3;
    logic        out_ready3;
    logic [31:0] q3;
    logic [1:0]  count3;

    // depth = 1 instance
    logic        flush1;
    logic        in_valid1;
    logic        in_ready1;
    logic [31:0] d1;
    logic        out_valid1;
    logic        out_ready1;
    logic [31:0] q1;
    logic [0:0]  count1;

    int n_compared;
    int n_mismatched;

    pipe_reg #(
        .n           (32),
        .depth       (3),
        .reset_value (32'h0)
    ) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .d         (d3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .q         (q3),
        .count     (count3)
    );

    pipe_reg #(
        .n           (32),
        .depth       (1),
        .reset_value (32'h0)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .d         (d1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .q         (q1),
        .count     (count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset      = 1'b0;
        flush3     = 1'b0;
        in_valid3  = 1'b0;
        d3         = '0;
        out_ready3 = 1'b0;
        flush1     = 1'b0;
        in_valid1  = 1'b0;
        d1         = '0;
        out_ready1 = 1'b0;

        // ---- reset state ----
        #2;
        check_eq("rst_out_valid3", {31'b0, out_valid3}, 32'd0);
        check_eq("rst_count3",     {30'b0, count3},     32'd0);
        check_eq("rst_q3",         q3,                  32'h0);
        check_eq("rst_in_ready3",  {31'b0, in_ready3},  32'd0);
        check_eq("rst_in_ready1",  {31'b0, in_ready1},  32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("rel_in_ready3", {31'b0, in_ready3}, 32'd1);

        // ---- 1: asynchronous reset mid-stream ----
        in_valid3 = 1'b1;
        d3        = 32'h100;
        tick;
        d3 = 32'h101;
        tick;
        in_valid3 = 1'b0;
        check_eq("t1_fill_count", {30'b0, count3}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t1_async_out_valid", {31'b0, out_valid3}, 32'd0);
        check_eq("t1_async_count",     {30'b0, count3},     32'd0);
        check_eq("t1_async_q",         q3,                  32'h0);
        check_eq("t1_async_in_ready",  {31'b0, in_ready3},  32'd0);
        #1;
        reset = 1'b1;
        #1;
        check_eq("t1_rel_in_ready", {31'b0, in_ready3}, 32'd1);

        // ---- 2: streaming, depth 3 ----
        out_ready3 = 1'b1;
        in_valid3  = 1'b1;
        d3 = 32'd1; tick;
        check_eq("t2_e0_out_valid", {31'b0, out_valid3}, 32'd0);
        check_eq("t2_e0_count",     {30'b0, count3},     32'd1);
        d3 = 32'd2; tick;
        check_eq("t2_e1_out_valid", {31'b0, out_valid3}, 32'd0);
        check_eq("t2_e1_count",     {30'b0, count3},     32'd2);
        d3 = 32'd3; tick;
        check_eq("t2_e2_out_valid", {31'b0, out_valid3}, 32'd1);
        check_eq("t2_e2_q",         q3,                  32'd1);
        check_eq("t2_e2_count",     {30'b0, count3},     32'd3);
        d3 = 32'd4; tick;
        check_eq("t2_e3_q",     q3,              32'd2);
        check_eq("t2_e3_count", {30'b0, count3}, 32'd3);
        in_valid3 = 1'b0; tick;
        check_eq("t2_e4_q",     q3,              32'd3);
        check_eq("t2_e4_count", {30'b0, count3}, 32'd2);
        tick;
        check_eq("t2_e5_q",     q3,              32'd4);
        check_eq("t2_e5_count", {30'b0, count3}, 32'd1);
        tick;
        check_eq("t2_e6_out_valid", {31'b0, out_valid3}, 32'd0);
        check_eq("t2_e6_count",     {30'b0, count3},     32'd0);

        // ---- 3: back-pressure ----
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        d3 = 32'hA; tick;
        d3 = 32'hB; tick;
        d3 = 32'hC; tick;
        d3 = 32'hD;
        check_eq("t3_full_count",    {30'b0, count3},     32'd3);
        check_eq("t3_full_in_ready", {31'b0, in_ready3},  32'd0);
        check_eq("t3_full_q",        q3,                  32'hA);
        tick;
        check_eq("t3_stall_q",     q3,              32'hA);
        check_eq("t3_stall_count", {30'b0, count3}, 32'd3);
        out_ready3 = 1'b1;
        #1;
        check_eq("t3_rel_in_ready", {31'b0, in_ready3}, 32'd1);
        tick;
        check_eq("t3_q_b",     q3,              32'hB);
        check_eq("t3_count_b", {30'b0, count3}, 32'd3);
        in_valid3 = 1'b0; tick;
        check_eq("t3_q_c", q3, 32'hC);
        tick;
        check_eq("t3_q_d", q3, 32'hD);
        tick;
        check_eq("t3_empty_out_valid", {31'b0, out_valid3}, 32'd0);
        check_eq("t3_empty_count",     {30'b0, count3},     32'd0);

        // ---- 4: bubble collapse ----
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        d3 = 32'h11; tick;
        in_valid3 = 1'b0; tick; tick;
        check_eq("t4_lone_q", q3, 32'h11);
        in_valid3 = 1'b1;
        d3 = 32'h22; tick;
        check_eq("t4_q",        q3,                 32'h11);
        check_eq("t4_count2",   {30'b0, count3},    32'd2);
        check_eq("t4_in_ready", {31'b0, in_ready3}, 32'd1);
        d3 = 32'h33; tick;
        check_eq("t4_count3",       {30'b0, count3},    32'd3);
        check_eq("t4_full_in_ready", {31'b0, in_ready3}, 32'd0);

        // ---- 5: flush ----
        in_valid3  = 1'b0;
        out_ready3 = 1'b1;
        tick; tick; tick;
        check_eq("t5_drained_count", {30'b0, count3}, 32'd0);
        out_ready3 = 1'b0;
        in_valid3  = 1'b1;
        d3 = 32'h5; tick;
        d3 = 32'h6; tick;
        d3 = 32'h7; tick;
        flush3     = 1'b1;
        out_ready3 = 1'b1;
        d3         = 32'h9;
        #1;
        check_eq("t5_flush_in_ready",  {31'b0, in_ready3},  32'd0);
        check_eq("t5_flush_out_valid", {31'b0, out_valid3}, 32'd1);
        check_eq("t5_flush_q",         q3,                  32'h5);
        tick;
        flush3    = 1'b0;
        in_valid3 = 1'b0;
        check_eq("t5_post_count",     {30'b0, count3},     32'd0);
        check_eq("t5_post_out_valid", {31'b0, out_valid3}, 32'd0);
        tick; tick; tick;
        check_eq("t5_never_9", {31'b0, out_valid3}, 32'd0);

        // ---- 6: depth 1 ----
        check_eq("t6_empty_in_ready", {31'b0, in_ready1}, 32'd1);
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d1 = 32'(i);
            tick;
            check_eq("t6_stream_valid", {31'b0, out_valid1}, 32'd1);
            check_eq("t6_stream_q",     q1,                  32'(i));
            check_eq("t6_stream_count", {31'b0, count1},     32'd1);
        end
        d1         = 32'd8;
        out_ready1 = 1'b0;
        #1;
        check_eq("t6_stall_in_ready", {31'b0, in_ready1}, 32'd0);
        tick;
        check_eq("t6_stall_q", q1, 32'd7);
        out_ready1 = 1'b1;
        #1;
        check_eq("t6_go_in_ready", {31'b0, in_ready1}, 32'd1);
        tick;
        check_eq("t6_go_q", q1, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised multi-stage pipeline register with per-stage valid bits and a valid/ready handshake. It succeeds the plain n-bit D flip-flop.
- Adds depth, load enable per stage, bubble collapse, back-pressure, synchronous flush and an occupancy count.
- Used between datapath stages of the processor and on any elastic n-bit path that needs registered, stallable transport.

Parameters:
n, 32, data width in bits (n >= 1)
depth, 2, number of register stages (depth >= 1)
reset_value, {n{1'b0}}, value loaded into every data stage on reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = asserted); deassertion is synchronous to clk at system level
flush  input  1  synchronous flush, discards all stored items
in_valid  input  1  upstream presents d
in_ready  output  1  pipe accepts d this cycle
d  input  n  data in
out_valid  output  1  q holds a valid item
out_ready  input  1  downstream accepts q this cycle
q  output  n  data out (last stage register)
count  output  $clog2(depth+1)  number of valid stages

Behaviour:
- Storage: stages 0..depth-1, each with data reg data[i] and valid bit v[i]. Stage 0 is the input end; q = data[depth-1]; out_valid = v[depth-1].
- Reset (reset=0, asynchronous, effective immediately):
  - all v[i]=0 and all data[i]=reset_value.
  - q=reset_value, out_valid=0, count=0.
  - in_ready forced 0 while reset=0.
  - Reset mid-stream drops every stored item with no handshake.
- Stage advance rule, combinational, evaluated from output back to input:
  - adv[depth-1] = !v[depth-1] || out_ready
  - adv[i] = !v[i] || adv[i+1]
  - in_ready = adv[0] && !flush && reset
- On each rising edge, with no flush:
  - Stage i (i>0): if adv[i], then v[i] <= v[i-1] and data[i] <= data[i-1], but data loads only when v[i-1]=1, otherwise data holds.
  - Stage 0: if adv[0], then v[0] <= in_valid and data[0] <= d, but data loads only when in_valid=1.
  - Stages with adv=0 hold data and valid unchanged.
- Bubble collapse: an item advances into an empty stage even when downstream is stalled, so stored items compact toward the output.
- Transfers:
  - An input transfer happens when in_valid && in_ready at the edge.
  - An output transfer happens when out_valid && out_ready at the edge.
  - Simultaneous input and output transfers are legal when full; throughput is 1 item/cycle at every depth, including depth=1.
- Latency: an item accepted at edge k into an empty pipe is presented at q (out_valid=1) after edge k+depth-1, i.e. depth cycles after in_valid is sampled.
- Ordering: strict FIFO. No item is lost or duplicated except by flush or reset.
- count: registered, equals popcount of v. It updates each edge: +1 on input transfer, -1 on output transfer, unchanged when both or neither occur.
- Flush (flush=1 at edge):
  - all v[i] <= 0 and count <= 0.
  - Data regs hold their values; q is don't-care while out_valid=0.
  - in_ready=0 during the flush cycle, so in_valid is ignored and nothing enters.
  - out_valid/q remain as stored during the flush cycle. If out_ready=1, that output transfer completes, so the consumer receives the item. All other items are discarded.
- Empty: out_valid=0, count=0, in_ready=1.
- Full: all v=1 and count=depth; in_ready=out_ready.
- out_valid, once high, stays high with q stable until an output transfer, flush or reset.

Test Plan:
1. Reset (n=32, depth=3, reset_value=0): fill to count=2, then pulse reset=0 between edges -> out_valid=0, count=0, q=0, in_ready=0 immediately without a clock edge; after reset=1, in_ready=1.
2. Streaming (depth=3): out_ready=1, in_valid=1, d=1,2,3,4 on consecutive edges -> out_valid rises 3 cycles after d=1 is sampled; q=1,2,3,4 on consecutive cycles; count settles at 3, then drains 2,1,0.
3. Back-pressure (depth=3): out_ready=0, offer 0xA,0xB,0xC,0xD -> first three accepted, count=3, in_ready=0 while 0xD is offered, q=0xA stable. Then out_ready=1 -> q=0xA,0xB,0xC,0xD in order with no loss or duplication.
4. Bubble collapse (depth=3, out_ready=0): push 0x11, idle 2 cycles, push 0x22 -> q=0x11, count=2, in_ready=1. Push 0x33 -> count=3, in_ready=0.
5. Flush (depth=3, full, q=0x5): flush=1 for one cycle with out_ready=1 and in_valid=1, d=0x9 -> 0x5 is consumed that cycle; next cycle count=0, out_valid=0; 0x9 is never delivered.
6. depth=1: out_ready=1 with continuous in_valid, d=0..7 -> one item per cycle, 1-cycle latency. Toggle out_ready 1,0,1 -> q holds while stalled and in_ready tracks out_ready.
